apb_slave_regfile: RTL and testbench
====================================

Name: apb_slave_regfile

Overview:
APB completer (slave) that terminates the master-driven psel/penable/pwrite/paddr/pwdata bus, the other end of the team's APB interface. It implements a small word-addressed register bank. The block inserts a configurable number of wait states via pready and reports decode and access errors on pslverr. Register 0 is exported as a control word, and the top register is a read-only status mirror of an input vector.

Parameters:
ADDR_WIDTH, 32, width of paddr
DATA_WIDTH, 32, width of pwdata/prdata and of each register
NUM_REGS, 8, number of 32-bit registers (legal range 2..256); byte offsets 0,4,...,4*(NUM_REGS-1)
WAIT_STATES, 1, access-phase cycles with pready=0 before the completion cycle (legal range 0..15)

Ports:
pclk  input  1  APB clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
paddr  input  ADDR_WIDTH  byte address
psel  input  1  completer select
penable  input  1  access-phase indicator
pwrite  input  1  1=write, 0=read
pwdata  input  DATA_WIDTH  write data
pready  output  1  transfer completion
prdata  output  DATA_WIDTH  read data, valid only in the completion cycle
pslverr  output  1  error response, valid only in the completion cycle
status_in  input  DATA_WIDTH  value returned by reads of register NUM_REGS-1
ctrl_reg0  output  DATA_WIDTH  current contents of register 0

Behaviour:
- Reset (async assert, sync deassert by the caller): FSM=IDLE, wait counter=0, all RW registers=0, pready=0, prdata=0, pslverr=0, ctrl_reg0=0.
- All outputs are registered. pready, prdata and pslverr are 0 in every cycle except the completion cycle.
- FSM states: IDLE, SETUP, WAIT, DONE.
  - IDLE: psel=1 and penable=0 moves to SETUP. paddr, pwrite and pwdata are captured at that edge.
  - SETUP (first access cycle follows): if WAIT_STATES=0, go to DONE. Otherwise load counter=WAIT_STATES-1 and go to WAIT.
  - WAIT: counter decrements each cycle; at 0 go to DONE.
  - DONE: pready=1 for exactly one cycle. Next state is SETUP if psel=1 and penable=0 at that edge (back-to-back transfer), else IDLE.
- Latency: the setup cycle is followed by WAIT_STATES cycles of pready=0, then one cycle of pready=1. Total transfer length is WAIT_STATES+2 cycles.
- Decode: idx = paddr[ADDR_WIDTH-1:2]. An error is flagged if any of the following holds:
  - paddr[1:0] != 0 (unaligned)
  - idx >= NUM_REGS (out of range)
  - pwrite=1 and idx = NUM_REGS-1 (write to read-only status)
- Write (no error): the register updates at the edge that ends the completion cycle. ctrl_reg0 reflects the new value from the next cycle.
- Read (no error): prdata holds the register value, or status_in sampled on the edge entering DONE for idx NUM_REGS-1.
- Error: pslverr=1 with pready=1. No register changes. prdata=0.
- Abort: if psel=0 or penable=0 in any WAIT cycle or the DONE-entry cycle, return to IDLE. No write occurs and pready is never asserted.
- Reset asserted mid-transfer: immediate return to reset values. A pending write is discarded.
- Address fields captured at setup are used throughout. Changes to paddr/pwdata during access are ignored.

Test Plan:
- Reset then read all offsets 0x00..0x18: each completes with pready after 1 wait cycle, prdata=0, pslverr=0. Read 0x1C with status_in=0xCAFE_F00D: prdata=0xCAFEF00D.
- Write 0xDEADBEEF to 0x00, then read 0x00: prdata=0xDEADBEEF, ctrl_reg0=0xDEADBEEF from the cycle after write completion, each transfer 3 cycles long.
- Errors: write to 0x1C, read 0x20, write 0x06 -> each has pslverr=1 with pready=1; register contents are unchanged on readback.
- Back-to-back: write 0x04=0x11, write 0x08=0x22, read 0x04 with no idle cycles between -> three pready pulses 3 cycles apart, read returns 0x11.
- WAIT_STATES=0 and WAIT_STATES=15 builds: pready arrives in access cycle 1 and access cycle 16 respectively; drop penable at wait cycle 5 -> no pready and no write.
- Assert rst_n=0 during the wait phase of a write of 0x55 to 0x00 -> outputs clear asynchronously and a later read of 0x00 returns 0.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// APB completer with a word-addressed register bank, configurable wait states and pslverr decode.
// Register 0 drives ctrl_reg0; the top register reads back status_in and rejects writes.
module apb_slave_regfile #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  pclk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr,
  input  logic [DATA_WIDTH-1:0] status_in,
  output logic [DATA_WIDTH-1:0] ctrl_reg0
);

  localparam int IDXW = ADDR_WIDTH - 2;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_REGS - 1);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wr_q, wr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS-1];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS-1];
  logic                    pready_q, pready_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    pslverr_q, pslverr_d;

  logic                    start;
  logic                    access;
  logic                    err_q;
  logic                    err_d;
  logic [IDXW-1:0]         idx_q;
  logic [IDXW-1:0]         idx_d;
  logic [DATA_WIDTH-1:0]   rd_val;

  function automatic logic decode_err(input logic [ADDR_WIDTH-1:0] a, input logic w);
    logic [IDXW-1:0] idx;
    idx = a[ADDR_WIDTH-1:2];
    return (a[1:0] != 2'b00) || (idx > LAST_IDX) || (w && (idx == LAST_IDX));
  endfunction

  assign start  = psel && !penable;
  assign access = psel && penable;
  assign idx_q  = addr_q[ADDR_WIDTH-1:2];
  assign err_q  = decode_err(addr_q, wr_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    regs_d    = regs_q;
    pready_d  = 1'b0;
    prdata_d  = '0;
    pslverr_d = 1'b0;
    rd_val    = '0;

    // The setup decision is taken on the capture edge so that WAIT_STATES=0
    // completes in the first access cycle.
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = paddr;
          wr_d    = pwrite;
          wdata_d = pwdata;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_STATES == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (!access) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (wr_q && !err_q) begin
          for (int i = 0; i < NUM_REGS - 1; i++) begin
            if (idx_q == IDXW'(i)) regs_d[i] = wdata_q;
          end
        end
        if (start) begin
          addr_d  = paddr;
          wr_d    = pwrite;
          wdata_d = pwdata;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_STATES == 0) ? DONE : WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    idx_d = addr_d[ADDR_WIDTH-1:2];
    err_d = decode_err(addr_d, wr_d);
    if (idx_d == LAST_IDX) rd_val = status_in;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      if (idx_d == IDXW'(i)) rd_val = regs_d[i];
    end

    // Responses are registered on the edge entering DONE.
    if (state_d == DONE) begin
      pready_d  = 1'b1;
      pslverr_d = err_d;
      prdata_d  = (!err_d && !wr_d) ? rd_val : '0;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      for (int i = 0; i < NUM_REGS - 1; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      regs_q    <= regs_d;
    end
  end

  assign pready    = pready_q;
  assign prdata    = prdata_q;
  assign pslverr   = pslverr_q;
  assign ctrl_reg0 = regs_q[0];

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: main instance with one wait state, plus zero- and fifteen-wait-state instances.
module tb_apb_slave_regfile;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, status_in;
  logic        pready, pslverr;
  logic [31:0] prdata, ctrl_reg0;

  logic        b_psel, b_penable, b_pwrite;
  logic [31:0] b_paddr, b_pwdata;
  logic        z_pready, z_pslverr, f_pready, f_pslverr;
  logic [31:0] z_prdata, z_ctrl, f_prdata, f_ctrl;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  apb_slave_regfile #(.WAIT_STATES(1)) dut (
    .pclk(pclk), .rst_n(rst_n), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready), .prdata(prdata),
    .pslverr(pslverr), .status_in(status_in), .ctrl_reg0(ctrl_reg0));

  apb_slave_regfile #(.WAIT_STATES(0)) dut_ws0 (
    .pclk(pclk), .rst_n(rst_n), .paddr(b_paddr), .psel(b_psel), .penable(b_penable),
    .pwrite(b_pwrite), .pwdata(b_pwdata), .pready(z_pready), .prdata(z_prdata),
    .pslverr(z_pslverr), .status_in(status_in), .ctrl_reg0(z_ctrl));

  apb_slave_regfile #(.WAIT_STATES(15)) dut_ws15 (
    .pclk(pclk), .rst_n(rst_n), .paddr(b_paddr), .psel(b_psel), .penable(b_penable),
    .pwrite(b_pwrite), .pwdata(b_pwdata), .pready(f_pready), .prdata(f_prdata),
    .pslverr(f_pslverr), .status_in(status_in), .ctrl_reg0(f_ctrl));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transfer on the main bus; returns once pready is seen (or the bound expires).
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int n, output int dc);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(negedge pclk);
    penable = 1'b1;
    paddr   = a ^ 32'h4;
    pwdata  = ~d;
    n = 1;
    while (pready !== 1'b1 && n < 40) begin
      @(negedge pclk);
      n++;
    end
    chk("xfer_pready", {31'b0, pready}, 32'd1);
    rd = prdata;
    er = pslverr;
    dc = cyc;
  endtask

  task automatic go_idle();
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          n, c1, c2, c3, nz, nf, seen;

    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; status_in = '0;
    b_psel = 1'b0; b_penable = 1'b0; b_pwrite = 1'b0; b_paddr = '0; b_pwdata = '0;
    repeat (3) @(negedge pclk);
    chk("rst_pready", {31'b0, pready}, 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_pslverr", {31'b0, pslverr}, 32'd0);
    chk("rst_ctrl", ctrl_reg0, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      xfer(1'b0, 32'(i * 4), 32'h0, rd, er, n, c1);
      chk("rd_zero_data", rd, 32'd0);
      chk("rd_zero_err", {31'b0, er}, 32'd0);
      chk("rd_zero_len", 32'(n), 32'd2);
    end
    go_idle();
    status_in = 32'hCAFE_F00D;
    xfer(1'b0, 32'h1C, 32'h0, rd, er, n, c1);
    chk("rd_status", rd, 32'hCAFE_F00D);
    chk("rd_status_err", {31'b0, er}, 32'd0);

    go_idle();
    xfer(1'b1, 32'h00, 32'hDEAD_BEEF, rd, er, n, c1);
    chk("wr0_len", 32'(n), 32'd2);
    chk("wr0_err", {31'b0, er}, 32'd0);
    chk("wr0_prdata", rd, 32'd0);
    chk("ctrl_before", ctrl_reg0, 32'd0);
    go_idle();
    chk("ctrl_after", ctrl_reg0, 32'hDEAD_BEEF);
    xfer(1'b0, 32'h00, 32'h0, rd, er, n, c1);
    chk("rd0", rd, 32'hDEAD_BEEF);
    chk("rd0_len", 32'(n), 32'd2);

    go_idle();
    xfer(1'b1, 32'h1C, 32'h1234_5678, rd, er, n, c1);
    chk("err_wr_status", {31'b0, er}, 32'd1);
    xfer(1'b0, 32'h20, 32'h0, rd, er, n, c1);
    chk("err_rd_range", {31'b0, er}, 32'd1);
    chk("err_rd_range_data", rd, 32'd0);
    xfer(1'b1, 32'h06, 32'h0000_0BAD, rd, er, n, c1);
    chk("err_unaligned", {31'b0, er}, 32'd1);
    xfer(1'b0, 32'h04, 32'h0, rd, er, n, c1);
    chk("err_rb4", rd, 32'd0);
    xfer(1'b0, 32'h1C, 32'h0, rd, er, n, c1);
    chk("err_rb_status", rd, 32'hCAFE_F00D);
    xfer(1'b0, 32'h00, 32'h0, rd, er, n, c1);
    chk("err_rb0", rd, 32'hDEAD_BEEF);

    go_idle();
    xfer(1'b1, 32'h04, 32'h11, rd, er, n, c1);
    xfer(1'b1, 32'h08, 32'h22, rd, er, n, c2);
    xfer(1'b0, 32'h04, 32'h0, rd, er, n, c3);
    chk("b2b_gap1", 32'(c2 - c1), 32'd3);
    chk("b2b_gap2", 32'(c3 - c2), 32'd3);
    chk("b2b_rd4", rd, 32'h11);
    xfer(1'b0, 32'h08, 32'h0, rd, er, n, c1);
    chk("b2b_rd8", rd, 32'h22);

    go_idle();
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h55;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", ctrl_reg0, 32'd0);
    chk("mid_rst_pready", {31'b0, pready}, 32'd0);
    chk("mid_rst_prdata", prdata, 32'd0);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    rst_n = 1'b1;
    xfer(1'b0, 32'h00, 32'h0, rd, er, n, c1);
    chk("post_rst_rd0", rd, 32'd0);
    xfer(1'b0, 32'h04, 32'h0, rd, er, n, c1);
    chk("post_rst_rd4", rd, 32'd0);
    go_idle();

    @(negedge pclk);
    b_psel = 1'b1; b_penable = 1'b0; b_pwrite = 1'b0; b_paddr = 32'h0;
    @(negedge pclk);
    b_penable = 1'b1;
    nz = 0; nf = 0;
    for (int k = 1; k <= 40 && nf == 0; k++) begin
      if (z_pready === 1'b1 && nz == 0) nz = k;
      if (f_pready === 1'b1) nf = k;
      else @(negedge pclk);
    end
    chk("ws0_access_cycle", 32'(nz), 32'd1);
    chk("ws15_access_cycle", 32'(nf), 32'd16);
    @(negedge pclk);
    b_psel = 1'b0; b_penable = 1'b0;

    @(negedge pclk);
    b_psel = 1'b1; b_penable = 1'b0; b_pwrite = 1'b1; b_paddr = 32'h0; b_pwdata = 32'h77;
    @(negedge pclk);
    b_penable = 1'b1;
    seen = 0;
    repeat (4) begin
      if (f_pready === 1'b1) seen++;
      @(negedge pclk);
    end
    b_penable = 1'b0;
    @(negedge pclk);
    b_psel = 1'b0;
    repeat (25) begin
      if (f_pready === 1'b1) seen++;
      @(negedge pclk);
    end
    chk("abort_no_pready", 32'(seen), 32'd0);
    chk("abort_no_write", f_ctrl, 32'd0);
    chk("ws0_write", z_ctrl, 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
